// File: rtl/maxpool_flex_sched.sv
// maxpool_flex_sched: sequencer around the serial 1D max-pool datapath.
// It accepts an A/B pair of parallel feature words per channel. It streams
// the pair LSW-first as 2*BW_IN/SER_BW back-to-back beats. It then waits for
// the pooled result, with a timeout, and hands the result downstream over
// valid/ready. Only one pair is in flight at a time.
// Optional: define MAXPOOL_SCHED_STATS_EN to add the stat_pairs/stat_stall
// counters.
module maxpool_flex_sched #(
  parameter int NO_CH      = 10,
  parameter int BW_IN      = 12,
  parameter int SER_BW     = 4,
  parameter int MP_LATENCY = 3,
  parameter int TIMEOUT    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_vld,
  output logic                             in_rdy,
  input  logic [NO_CH-1:0][BW_IN-1:0]      in_data_a,
  input  logic [NO_CH-1:0][BW_IN-1:0]      in_data_b,
  output logic                             mp_vld_in,
  output logic [NO_CH-1:0][SER_BW-1:0]     mp_data_in,
  input  logic                             mp_vld_out,
  input  logic [NO_CH-1:0][BW_IN-1:0]      mp_data_out,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic [NO_CH-1:0][BW_IN-1:0]      out_data,
  output logic                             busy,
  output logic                             err
`ifdef MAXPOOL_SCHED_STATS_EN
  ,
  output logic [31:0]                      stat_pairs,
  output logic [31:0]                      stat_stall
`endif
);

  localparam int W      = BW_IN / SER_BW;
  localparam int NB     = 2 * W;
  localparam int LIMIT  = MP_LATENCY + TIMEOUT;
  localparam int BEAT_W = $clog2(NB) + 1;
  localparam int WAIT_W = $clog2(LIMIT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [NO_CH-1:0][BW_IN-1:0]     a_q, a_d;
  logic [NO_CH-1:0][BW_IN-1:0]     b_q, b_d;
  logic [BEAT_W-1:0]               beat_q, beat_d;
  logic [WAIT_W-1:0]               wait_q, wait_d;
  logic                            in_rdy_q, in_rdy_d;
  logic                            mp_vld_in_q, mp_vld_in_d;
  logic [NO_CH-1:0][SER_BW-1:0]    mp_data_in_q, mp_data_in_d;
  logic                            out_vld_q, out_vld_d;
  logic [NO_CH-1:0][BW_IN-1:0]     out_data_q, out_data_d;
  logic                            err_q, err_d;

  // Slice k of the serialized pair: beats 0..W-1 come from A, W..NB-1 from B.
  function automatic logic [NO_CH-1:0][SER_BW-1:0] beat_slice(
    input logic [NO_CH-1:0][BW_IN-1:0] a,
    input logic [NO_CH-1:0][BW_IN-1:0] b,
    input logic [BEAT_W-1:0]           k
  );
    int unsigned kk;
    beat_slice = '0;
    kk = 32'(k);
    for (int unsigned ch = 0; ch < NO_CH; ch++) begin
      if (kk < W) beat_slice[ch] = a[ch][kk*SER_BW +: SER_BW];
      else        beat_slice[ch] = b[ch][(kk-W)*SER_BW +: SER_BW];
    end
  endfunction

  // Next-state logic for the sequencer, the beat/wait counters and the registered outputs.
  // The beat outputs are loaded one cycle early: the first slice is loaded on
  // the accept edge, so beat_q always indexes the beat currently on mp_data_in.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    mp_vld_in_d  = 1'b0;
    mp_data_in_d = '0;
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    err_d        = err_q;

    if (out_vld_q && out_rdy) out_vld_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_vld && in_rdy_q) begin
          a_d          = in_data_a;
          b_d          = in_data_b;
          beat_d       = '0;
          mp_vld_in_d  = 1'b1;
          mp_data_in_d = beat_slice(in_data_a, in_data_b, '0);
          state_d      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (beat_q == BEAT_W'(NB - 1)) begin
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          beat_d       = beat_q + 1'b1;
          mp_vld_in_d  = 1'b1;
          mp_data_in_d = beat_slice(a_q, b_q, beat_q + 1'b1);
        end
      end
      S_WAIT: begin
        if (mp_vld_out) begin
          out_data_d = mp_data_out;
          out_vld_d  = 1'b1;
          state_d    = S_IDLE;
        end else if (wait_q == WAIT_W'(LIMIT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (mp_vld_out && (state_q != S_WAIT)) err_d = 1'b1;

    // Registered ready: it rises only in the cycle after the downstream
    // handshake has cleared out_vld.
    in_rdy_d = (state_d == S_IDLE) && !out_vld_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      beat_q       <= '0;
      wait_q       <= '0;
      in_rdy_q     <= 1'b0;
      mp_vld_in_q  <= 1'b0;
      mp_data_in_q <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
      in_rdy_q     <= in_rdy_d;
      mp_vld_in_q  <= mp_vld_in_d;
      mp_data_in_q <= mp_data_in_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      err_q        <= err_d;
    end
  end

  assign in_rdy     = in_rdy_q;
  assign mp_vld_in  = mp_vld_in_q;
  assign mp_data_in = mp_data_in_q;
  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);

`ifdef MAXPOOL_SCHED_STATS_EN
  logic [31:0] stat_pairs_q, stat_pairs_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Count output handshakes and cycles stalled by the downstream side (wrapping).
  always_comb begin
    stat_pairs_d = stat_pairs_q;
    stat_stall_d = stat_stall_q;
    if (out_vld_q && out_rdy)  stat_pairs_d = stat_pairs_q + 32'd1;
    if (out_vld_q && !out_rdy) stat_stall_d = stat_stall_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pairs_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_pairs_q <= stat_pairs_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_pairs = stat_pairs_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_maxpool_flex_sched.sv
// Directed bench for maxpool_flex_sched. The bench includes a behavioural
// serial max-pool: it reassembles the beats, takes the signed max, and
// answers MP_LATENCY cycles after the last beat.
module tb_maxpool_flex_sched;

  localparam int NO_CH = 2;
  localparam int BW_IN = 12;
  localparam int SER_BW = 4;
  localparam int MPL = 3;
  localparam int TO = 8;
  localparam int W = BW_IN / SER_BW;
  localparam int NB = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_vld = 1'b0;
  logic in_rdy;
  logic [NO_CH-1:0][BW_IN-1:0] in_data_a = '0;
  logic [NO_CH-1:0][BW_IN-1:0] in_data_b = '0;
  logic mp_vld_in;
  logic [NO_CH-1:0][SER_BW-1:0] mp_data_in;
  logic mp_vld_out;
  logic [NO_CH-1:0][BW_IN-1:0] mp_data_out;
  logic out_vld;
  logic out_rdy = 1'b1;
  logic [NO_CH-1:0][BW_IN-1:0] out_data;
  logic busy;
  logic err;

  logic mp_en = 1'b1;
  logic spur = 1'b0;

  always #5 clk = ~clk;

  maxpool_flex_sched #(
    .NO_CH(NO_CH), .BW_IN(BW_IN), .SER_BW(SER_BW), .MP_LATENCY(MPL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_data_a(in_data_a), .in_data_b(in_data_b),
    .mp_vld_in(mp_vld_in), .mp_data_in(mp_data_in),
    .mp_vld_out(mp_vld_out), .mp_data_out(mp_data_out),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .busy(busy), .err(err)
  );

  // Behavioural serial max-pool sharing the scheduler's reset.
  logic [NO_CH-1:0][BW_IN-1:0] ma, mb, mres;
  int mcnt;
  logic [MPL-1:0] pipe;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= 0;
      pipe <= '0;
      ma   <= '0;
      mb   <= '0;
      mres <= '0;
    end else begin
      pipe <= {pipe[MPL-2:0], (mp_vld_in && mcnt == NB - 1)};
      if (mp_vld_in) begin
        for (int ch = 0; ch < NO_CH; ch++) begin
          if (mcnt < W) ma[ch][mcnt*SER_BW +: SER_BW] <= mp_data_in[ch];
          else          mb[ch][(mcnt-W)*SER_BW +: SER_BW] <= mp_data_in[ch];
        end
        mcnt <= (mcnt == NB - 1) ? 0 : mcnt + 1;
      end
      if (pipe[0]) begin
        for (int ch = 0; ch < NO_CH; ch++)
          mres[ch] <= ($signed(ma[ch]) > $signed(mb[ch])) ? ma[ch] : mb[ch];
      end
    end
  end

  assign mp_vld_out  = (pipe[MPL-1] & mp_en) | spur;
  assign mp_data_out = mres;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_pair(input logic [11:0] a0, input logic [11:0] a1,
                           input logic [11:0] b0, input logic [11:0] b1);
    int n;
    @(negedge clk);
    in_data_a[0] = a0; in_data_a[1] = a1;
    in_data_b[0] = b0; in_data_b[1] = b1;
    in_vld = 1'b1;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_in_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_vld && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_out_vld_seen"}, 32'(out_vld), 32'd1);
  endtask

  typedef struct {
    logic [11:0] a0, a1, b0, b1, e0, e1;
  } vec_t;

  vec_t vt[5];
  logic [3:0] exp_nib[6];
  int bad;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{a0:12'hABC, a1:12'h005, b0:12'h123, b1:12'h003, e0:12'h123, e1:12'h005};
    vt[1] = '{a0:12'h005, a1:12'hFFE, b0:12'h003, b1:12'h001, e0:12'h005, e1:12'h001};
    vt[2] = '{a0:12'h800, a1:12'h800, b0:12'h800, b1:12'h800, e0:12'h800, e1:12'h800};
    vt[3] = '{a0:12'h7FF, a1:12'hFFF, b0:12'h800, b1:12'hFFE, e0:12'h7FF, e1:12'hFFF};
    vt[4] = '{a0:12'h000, a1:12'h100, b0:12'hFFF, b1:12'h200, e0:12'h000, e1:12'h200};
    exp_nib = '{4'hC, 4'hB, 4'hA, 4'h3, 4'h2, 4'h1};

    // Reset state
    #12;
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_mp_vld_in", 32'(mp_vld_in), 32'd0);
    check("rst_mp_data_in", 32'(mp_data_in), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Beat order and contiguity
    send_pair(12'hABC, 12'h005, 12'h123, 12'h003);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      check($sformatf("beat%0d_vld", k), 32'(mp_vld_in), 32'd1);
      check($sformatf("beat%0d_ch0", k), 32'(mp_data_in[0]), 32'(exp_nib[k]));
    end
    @(negedge clk);
    check("beat_end_vld", 32'(mp_vld_in), 32'd0);
    check("beat_end_busy", 32'(busy), 32'd1);
    wait_result("beat");
    check("beat_res_ch0", 32'(out_data[0]), 32'h123);
    check("beat_res_ch1", 32'(out_data[1]), 32'h005);

    // Table of signed-max vectors
    for (int i = 0; i < 5; i++) begin
      send_pair(vt[i].a0, vt[i].a1, vt[i].b0, vt[i].b1);
      wait_result($sformatf("vec%0d", i));
      check($sformatf("vec%0d_ch0", i), 32'(out_data[0]), 32'(vt[i].e0));
      check($sformatf("vec%0d_ch1", i), 32'(out_data[1]), 32'(vt[i].e1));
      @(negedge clk);
      check($sformatf("vec%0d_pulse_once", i), 32'(out_vld), 32'd0);
      check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
    end

    // Backpressure: result holds, second pair blocked, accepted after release
    out_rdy = 1'b0;
    send_pair(12'h005, 12'hFFE, 12'h003, 12'h001);
    wait_result("bp1");
    check("bp1_data", 32'(out_data), 32'({12'h001, 12'h005}));
    in_data_a[0] = 12'h100; in_data_a[1] = 12'h800;
    in_data_b[0] = 12'h0FF; in_data_b[1] = 12'h801;
    in_vld = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_vld !== 1'b1 || out_data !== {12'h001, 12'h005} || in_rdy !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    check("bp_hold_cycles_bad", 32'(bad), 32'd0);
    out_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_out_vld", 32'(out_vld), 32'd0);
    check("bp_release_in_rdy", 32'(in_rdy), 32'd1);
    @(negedge clk);
    check("bp_accept_busy", 32'(busy), 32'd1);
    check("bp_accept_beat", 32'(mp_vld_in), 32'd1);
    in_vld = 1'b0;
    wait_result("bp2");
    check("bp2_ch0", 32'(out_data[0]), 32'h100);
    check("bp2_ch1", 32'(out_data[1]), 32'h801);

    // Timeout: no result from the max-pool
    mp_en = 1'b0;
    send_pair(12'h001, 12'h002, 12'h003, 12'h004);
    repeat (17) @(negedge clk);
    check("to_pre_err", 32'(err), 32'd0);
    check("to_pre_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("to_err", 32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_out_vld", 32'(out_vld), 32'd0);
    repeat (5) @(negedge clk);
    check("to_err_sticky", 32'(err), 32'd1);
    check("to_out_vld_later", 32'(out_vld), 32'd0);
    rst = 1'b0;
    #1;
    check("to_err_cleared_by_rst", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mp_en = 1'b1;

    // Spurious result in IDLE
    repeat (2) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spur_err", 32'(err), 32'd1);
    check("spur_out_vld", 32'(out_vld), 32'd0);
    check("spur_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Result on the same cycle as the timeout: the result wins
    mp_en = 1'b0;
    send_pair(12'h050, 12'hF00, 12'h060, 12'h0F0);
    repeat (17) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("race_out_vld", 32'(out_vld), 32'd1);
    check("race_err", 32'(err), 32'd0);
    check("race_data", 32'(out_data), 32'({12'h0F0, 12'h060}));
    mp_en = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-SHIFT after three beats
    send_pair(12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD);
    repeat (3) @(negedge clk);
    check("mid_shift_vld_before", 32'(mp_vld_in), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_mp_vld_in", 32'(mp_vld_in), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_pair(12'h3FF, 12'hF80, 12'h400, 12'hF7F);
    wait_result("post_rst");
    check("post_rst_ch0", 32'(out_data[0]), 32'h400);
    check("post_rst_ch1", 32'(out_data[1]), 32'hF80);
    check("post_rst_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxpool_flex_sched.md
Name: maxpool_flex_sched

Overview:
- Sequencer that feeds the serial 1D max-pool datapath (NO_CH channels, SER_BW-bit slices, LSW first) and collects its results.
- Accepts a pair of parallel feature words per channel (A = earlier time step, B = later) over valid/ready.
- Serializes the pair into the max-pool as 2*BW_IN/SER_BW back-to-back beats and waits for the pooled result.
- Presents the result downstream over valid/ready. One pair in flight at a time.

Parameters:
- NO_CH, 10, number of channels.
- BW_IN, 12, word width per channel in bits. Must be a multiple of SER_BW.
- SER_BW, 4, slice width per beat.
- MP_LATENCY, 3, max-pool cycles from the last beat to mp_vld_out. Used only to size the timeout.
- TIMEOUT, 8, extra cycles allowed in WAIT beyond MP_LATENCY before declaring an error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_vld  in  1  input pair valid.
- in_rdy  out  1  input pair accepted when in_vld && in_rdy.
- in_data_a  in  [NO_CH-1:0][BW_IN-1:0]  word A, signed.
- in_data_b  in  [NO_CH-1:0][BW_IN-1:0]  word B, signed.
- mp_vld_in  out  1  beat valid to the max-pool.
- mp_data_in  out  [NO_CH-1:0][SER_BW-1:0]  beat slice to the max-pool.
- mp_vld_out  in  1  result valid from the max-pool.
- mp_data_out  in  [NO_CH-1:0][BW_IN-1:0]  result from the max-pool.
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream ready.
- out_data  out  [NO_CH-1:0][BW_IN-1:0]  registered pooled result.
- busy  out  1  high whenever state != IDLE.
- err  out  1  sticky protocol/timeout error.

Behaviour:
- W = BW_IN/SER_BW; NB = 2*W.
- Reset values: state = IDLE; all outputs 0 (in_rdy, mp_vld_in, mp_data_in, out_vld, out_data, busy, err); all counters 0. Reset acts immediately, including mid-SHIFT or mid-WAIT. The max-pool's own reset must be asserted during the same interval so its beat counter stays aligned.
- States:
  - IDLE: in_rdy = !out_vld. On handshake, latch A and B, clear beat counter, go to SHIFT.
  - SHIFT: mp_vld_in = 1 for exactly NB consecutive cycles, with no gaps.
    - Beat k < W: mp_data_in[ch] = A[ch][k*SER_BW +: SER_BW].
    - Beat k >= W: mp_data_in[ch] = B[ch][(k-W)*SER_BW +: SER_BW].
    - After beat NB-1, go to WAIT with mp_vld_in = 0.
  - WAIT: wait counter increments each cycle.
    - On mp_vld_out: out_data <= mp_data_out, out_vld <= 1, go to IDLE.
    - If counter reaches MP_LATENCY+TIMEOUT first: err <= 1, go to IDLE, no output produced.
- mp_vld_in and mp_data_in are registered, so the first beat appears the cycle after the input handshake. in_rdy is low in SHIFT and WAIT.
- out_vld stays high until out_vld && out_rdy, then clears. out_data holds its value. A new pair cannot be accepted while out_vld = 1, so a result is never overwritten.
- mp_vld_out arriving outside WAIT sets err and is ignored.
- Simultaneous events:
  - out_vld && out_rdy in IDLE while in_vld is high: in_rdy is computed from the registered out_vld, so acceptance happens the following cycle.
  - Timeout reached on the same cycle as mp_vld_out: the result wins, err is not set.
- err clears only on reset.
- Counter widths: $clog2(NB)+1 for the beat counter, $clog2(MP_LATENCY+TIMEOUT)+1 for the wait counter. No wrap-around within legal operation.

Optional Feature:
- MAXPOOL_SCHED_STATS_EN defined:
  - Adds outputs stat_pairs [31:0] (increments on each out handshake) and stat_stall [31:0] (increments each cycle out_vld && !out_rdy).
  - Both reset to 0 and wrap modulo 2^32.
- Not defined: ports and logic absent, behaviour otherwise identical.

Test Plan (NO_CH=2, BW_IN=12, SER_BW=4, MP_LATENCY=3, TIMEOUT=8, paired with the real max-pool):
- Beat order: A ch0=0xABC, B ch0=0x123 -> mp_data_in ch0 = 0xC,0xB,0xA,0x3,0x2,0x1 on 6 consecutive cycles starting one cycle after the handshake; mp_vld_in high exactly 6 cycles.
- Signed max: A ch0=0x005/B ch0=0x003 -> 0x005; A ch1=0xFFE(-2)/B ch1=0x001 -> 0x001; A=B=0x800 -> 0x800; out_vld pulses once.
- Backpressure: out_rdy=0 for 10 cycles after result, second pair offered -> out_vld and out_data hold, in_rdy=0; release -> second pair accepted the next cycle.
- Timeout: mp_vld_out tied 0 -> 11 cycles into WAIT err=1, state IDLE, out_vld stays 0; err persists until rst=0.
- Spurious result: mp_vld_out=1 in IDLE -> err=1, out_vld unchanged.
- Reset mid-SHIFT after 3 beats: rst=0 asynchronously -> mp_vld_in=0 and busy=0 immediately; after release a fresh pair yields the correct max.
